// File: rtl/cp_theta_apply.sv
// Theta-apply stage: streams every state slice once per start and writes back
// a[x][y][z] ^ C[x-1][z] ^ C[x+1][z-1], using the column parities of the previous stage.
module cp_theta_apply #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [N-1:0] par_addr,
    input  logic [4:0]   par_data,
    output logic [N-1:0] st_addr,
    input  logic [24:0]  st_rdata,
    output logic [N-1:0] st_waddr,
    output logic [24:0]  st_wdata,
    output logic         st_we,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] z_q, z_d;
    logic         pre_valid_q, pre_valid_d;
    logic         wb_valid_q, wb_valid_d;
    logic [N-1:0] wb_z_q, wb_z_d;
    logic [4:0]   prev_c_q, prev_c_d;

    // Column-parity mix of one slice; identical for every row y, so one 5-bit
    // row pattern is computed and replicated across the five rows.
    function automatic logic [24:0] theta_mix(input logic [4:0] cur, input logic [4:0] prev);
        logic [4:0] row;
        row = '0;
        for (int x = 0; x < 5; x++) begin
            row[x] = cur[(x + 4) % 5] ^ prev[(x + 1) % 5];
        end
        return {5{row}};
    endfunction

    // NOTE: every signal assigned in this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        z_d      = z_q;
        par_addr = '0;
        st_addr  = '0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                busy     = 1'b1;
                par_addr = '1;
                z_d      = '0;
                state_d  = S_RUN;
            end
            S_RUN: begin
                busy     = 1'b1;
                par_addr = z_q;
                st_addr  = z_q;
                z_d      = z_q + 1'b1;
                if (&z_q) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy    = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read data returns one cycle after the address, so the write-back stage
    // trails the read stage by one register.  The PRE prefetch only seeds prev_c.
    always_comb begin
        pre_valid_d = (state_q == S_PRE);
        wb_valid_d  = (state_q == S_RUN);
        wb_z_d      = z_q;
        prev_c_d    = (pre_valid_q || wb_valid_q) ? par_data : prev_c_q;
    end

    always_comb begin
        st_we    = wb_valid_q;
        st_waddr = wb_valid_q ? wb_z_q : '0;
        st_wdata = wb_valid_q ? (st_rdata ^ theta_mix(par_data, prev_c_q)) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            z_q         <= '0;
            pre_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_z_q      <= '0;
            prev_c_q    <= '0;
        end else begin
            state_q     <= state_d;
            z_q         <= z_d;
            pre_valid_q <= pre_valid_d;
            wb_valid_q  <= wb_valid_d;
            wb_z_q      <= wb_z_d;
            prev_c_q    <= prev_c_d;
        end
    end

endmodule

// File: tb/tb_cp_theta_apply.sv
// Self-checking bench for cp_theta_apply: sync-read memory models, a write
// scoreboard filled at start time, and pass timing checks.
module tb_cp_theta_apply;

    localparam int N = 6;
    localparam int S = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] par_addr;
    logic [4:0]   par_data = '0;
    logic [N-1:0] st_addr;
    logic [24:0]  st_rdata = '0;
    logic [N-1:0] st_waddr;
    logic [24:0]  st_wdata;
    logic         st_we;
    logic         busy;
    logic         done;

    cp_theta_apply #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .par_addr (par_addr),
        .par_data (par_data),
        .st_addr  (st_addr),
        .st_rdata (st_rdata),
        .st_waddr (st_waddr),
        .st_wdata (st_wdata),
        .st_we    (st_we),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [4:0]  par_mem  [S];
    logic [24:0] st_mem   [S];
    logic [24:0] load_img [S];
    logic [24:0] model    [S];
    logic        load_req = 1'b0;

    typedef struct packed {
        logic [N-1:0] addr;
        logic [24:0]  data;
    } wr_t;
    wr_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int first_wr = 0;
    int last_wr = 0;
    int done_cnt = 0;
    int last_done = 0;
    int prev_done = 0;
    int e_cyc = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Sync-read memories; the state memory also takes the DUT writes and bulk loads.
    always @(posedge clk) begin
        par_data <= par_mem[par_addr];
        st_rdata <= st_mem[st_addr];
        if (load_req) begin
            for (int i = 0; i < S; i++) st_mem[i] <= load_img[i];
        end else if (st_we) begin
            st_mem[st_waddr] <= st_wdata;
        end
    end

    always @(negedge clk) begin
        if (st_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {38'd0, st_waddr}, 64'hffff);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", {58'd0, st_waddr}, {58'd0, e.addr});
                check("wr_data", {39'd0, st_wdata}, {39'd0, e.data});
            end
            if (wr_cnt == 0) first_wr = cyc;
            last_wr = cyc;
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            prev_done = last_done;
            last_done = cyc;
        end
    end

    function automatic logic [24:0] ref_slice(input logic [24:0] a, input logic [4:0] cur,
                                              input logic [4:0] prv);
        logic [24:0] r;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                r[5*y+x] = a[5*y+x] ^ cur[(x+4)%5] ^ prv[(x+1)%5];
            end
        end
        return r;
    endfunction

    task automatic load_state();
        for (int i = 0; i < S; i++) load_img[i] = model[i];
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // Push one pass worth of expected writes and advance the model past it.
    task automatic push_pass();
        wr_t e;
        for (int z = 0; z < S; z++) begin
            e.addr = z[N-1:0];
            e.data = ref_slice(model[z], par_mem[z], par_mem[(z+S-1)%S]);
            exp_q.push_back(e);
            model[z] = e.data;
        end
    endtask

    task automatic start_pass();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (done) break;
        end
        check(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic full_pass(input string tag);
        wr_cnt = 0;
        push_pass();
        start_pass();
        wait_done({tag, "_done"});
        check({tag, "_writes"}, wr_cnt, 64);
        check({tag, "_first_wr"}, first_wr - e_cyc, 2);
        check({tag, "_last_wr"}, last_wr - e_cyc, 65);
        check({tag, "_done_cyc"}, last_done - e_cyc, 66);
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < S; i++) begin
            par_mem[i] = '0;
            model[i]   = '0;
            load_img[i] = '0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_we", {63'd0, st_we}, 64'd0);
        check("rst_addrs", {par_addr, st_addr, st_waddr}, 64'd0);
        check("rst_wdata", {39'd0, st_wdata}, 64'd0);

        // 1: zero parity, random state -> pass-through write-back
        for (int i = 0; i < S; i++) model[i] = 25'($urandom);
        load_state();
        full_pass("t1");

        // 2: single parity bit C[0][5]
        for (int i = 0; i < S; i++) model[i] = '0;
        par_mem[5] = 5'b00001;
        load_state();
        full_pass("t2");
        check("t2_slice5", {39'd0, st_mem[5]}, 64'h0210842);
        check("t2_slice6", {39'd0, st_mem[6]}, 64'h1084210);
        check("t2_slice7", {39'd0, st_mem[7]}, 64'h0);

        // 3: wrap of z through C[2][63]
        par_mem[5] = '0;
        par_mem[63] = 5'b00100;
        for (int i = 0; i < S; i++) model[i] = '0;
        load_state();
        full_pass("t3");
        check("t3_slice0", {39'd0, st_mem[0]}, 64'h0210842);
        check("t3_slice63", {39'd0, st_mem[63]}, 64'h0842108);
        check("t3_slice1", {39'd0, st_mem[1]}, 64'h0);

        // 4: start re-asserted mid-pass and held through DONE is ignored
        for (int i = 0; i < S; i++) begin
            par_mem[i] = 5'($urandom);
            model[i]   = 25'($urandom);
        end
        load_state();
        wr_cnt = 0;
        done_cnt = 0;
        push_pass();
        start_pass();
        while (cyc < e_cyc + 9) @(negedge clk);
        start = 1'b1;
        wait_done("t4_done");
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("t4_writes", wr_cnt, 64);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_idle", {63'd0, busy}, 64'd0);
        check("t4_q_empty", exp_q.size(), 0);
        full_pass("t4_restart");

        // 5: reset during RUN at z=20, then a clean pass
        for (int i = 0; i < S; i++) model[i] = st_mem[i];
        wr_cnt = 0;
        done_cnt = 0;
        push_pass();
        start_pass();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy && st_addr == 6'd20) break;
        end
        check("t5_reached_z20", {58'd0, st_addr}, 64'd20);
        reset = 1'b1;
        @(negedge clk);
        check("t5_we_off", {63'd0, st_we}, 64'd0);
        check("t5_busy_off", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        repeat (70) @(negedge clk);
        check("t5_partial_writes", wr_cnt, 20);
        check("t5_no_done", done_cnt, 0);
        exp_q.delete();
        for (int i = 0; i < S; i++) model[i] = st_mem[i];
        full_pass("t5_after");

        // 6: start held high -> back-to-back passes 68 cycles apart
        for (int i = 0; i < S; i++) model[i] = st_mem[i];
        wr_cnt = 0;
        done_cnt = 0;
        push_pass();
        push_pass();
        @(negedge clk);
        start = 1'b1;
        wait_done("t6_done1");
        wait_done("t6_done2");
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_writes", wr_cnt, 128);
        check("t6_done_cnt", done_cnt, 2);
        check("t6_done_gap", last_done - prev_done, 68);
        check("t6_q_empty", exp_q.size(), 0);
        check("t6_idle", {63'd0, busy}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
